// File: rtl/uart_rx_buffer_ctrl_pkg.sv
// Shared UART receive-side constants: irqEnable bit positions and default baud counter width.
package uart_rx_buffer_ctrl_pkg;

  localparam int IRQ_THRESHOLD = 0;
  localparam int IRQ_TIMEOUT   = 1;
  localparam int IRQ_OVERRUN   = 2;

  localparam int CLOCK_SCALE_BITS_DEFAULT = 16;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible on o_dout the cycle after it lands.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_fifo #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic                 i_flush,
  input  logic [DATA_BITS-1:0] i_din,
  output logic [DATA_BITS-1:0] o_dout,
  output logic [ADDR_BITS:0]   o_count,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_push_ok,
  output logic                 o_pop_ok
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(DEPTH);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 w_push_ok;
  logic                 w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_push_ok = w_push_ok;
  assign o_pop_ok  = w_pop_ok;
  assign o_count   = r_count;
  assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage is not reset: pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// UART receive buffer: queues receiver bytes, flags overrun and character-idle timeout,
// and raises one registered interrupt (one cycle after a source becomes visible).
module uart_rx_buffer_ctrl
  import uart_rx_buffer_ctrl_pkg::*;
#(
  parameter int CLOCK_SCALE_BITS = CLOCK_SCALE_BITS_DEFAULT,
  parameter int FIFO_ADDR_BITS   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        flush,
  input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
  input  logic [7:0]                  rxDataIn,
  input  logic                        rxDataValid,
  input  logic                        readRequest,
  output logic [7:0]                  dataOut,
  output logic                        dataValid,
  output logic [FIFO_ADDR_BITS:0]     fifoCount,
  input  logic [FIFO_ADDR_BITS:0]     threshold,
  input  logic [7:0]                  timeoutBits,
  input  logic [2:0]                  irqEnable,
  input  logic                        clearOverrun,
  input  logic                        clearTimeout,
  output logic                        overrun,
  output logic                        timeout,
  output logic                        irq
);

  logic                        w_push_req;
  logic                        w_push_ok;
  logic                        w_pop_ok;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_overrun_set;
  logic                        w_timeout_set;
  logic [CLOCK_SCALE_BITS-1:0] w_presc_nxt;
  logic [7:0]                  w_idle_nxt;

  logic [CLOCK_SCALE_BITS-1:0] r_presc;
  logic [7:0]                  r_idle;
  logic                        r_overrun;
  logic                        r_timeout;
  logic                        r_irq;

  assign w_push_req = rxDataValid && enable;

  uart_fifo #(
    .ADDR_BITS(FIFO_ADDR_BITS),
    .DATA_BITS(8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push_req),
    .i_pop    (readRequest),
    .i_flush  (flush),
    .i_din    (rxDataIn),
    .o_dout   (dataOut),
    .o_count  (fifoCount),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_push_ok(w_push_ok),
    .o_pop_ok (w_pop_ok)
  );

  assign dataValid     = !w_empty;
  assign w_overrun_set = w_push_req && w_full && !w_pop_ok;

  // Prescaler period is cyclesPerBit+1 clocks; any FIFO activity restarts the idle measurement.
  always_comb begin
    w_presc_nxt = r_presc;
    w_idle_nxt  = r_idle;
    if (flush || w_push_ok || w_pop_ok || w_empty) begin
      w_presc_nxt = '0;
      w_idle_nxt  = '0;
    end else if (r_presc == cyclesPerBit) begin
      w_presc_nxt = '0;
      if (r_idle != 8'hFF) w_idle_nxt = r_idle + 1'b1;
    end else begin
      w_presc_nxt = r_presc + 1'b1;
    end
  end

  // Compare against the next idle count so the flag lands on the same edge the count does.
  assign w_timeout_set = (w_idle_nxt == timeoutBits) && (timeoutBits != 8'd0) &&
                         !w_empty && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= '0;
      r_idle    <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_presc <= w_presc_nxt;
      r_idle  <= w_idle_nxt;

      if (flush)              r_overrun <= 1'b0;
      else if (w_overrun_set) r_overrun <= 1'b1;
      else if (clearOverrun)  r_overrun <= 1'b0;

      if (flush)                          r_timeout <= 1'b0;
      else if (w_timeout_set)             r_timeout <= 1'b1;
      else if (clearTimeout || w_pop_ok)  r_timeout <= 1'b0;

      r_irq <= (irqEnable[IRQ_THRESHOLD] && (fifoCount >= threshold) && (threshold != '0)) ||
               (irqEnable[IRQ_TIMEOUT]   && r_timeout) ||
               (irqEnable[IRQ_OVERRUN]   && r_overrun);
    end
  end

  assign overrun = r_overrun;
  assign timeout = r_timeout;
  assign irq     = r_irq;

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Directed bench for uart_rx_buffer_ctrl with a byte scoreboard for FIFO ordering.
module tb_uart_rx_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        flush;
  logic [15:0] cyclesPerBit;
  logic [7:0]  rxDataIn;
  logic        rxDataValid;
  logic        readRequest;
  logic [7:0]  dataOut;
  logic        dataValid;
  logic [4:0]  fifoCount;
  logic [4:0]  threshold;
  logic [7:0]  timeoutBits;
  logic [2:0]  irqEnable;
  logic        clearOverrun;
  logic        clearTimeout;
  logic        overrun;
  logic        timeout;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_rx_buffer_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .cyclesPerBit(cyclesPerBit), .rxDataIn(rxDataIn), .rxDataValid(rxDataValid),
    .readRequest(readRequest), .dataOut(dataOut), .dataValid(dataValid),
    .fifoCount(fifoCount), .threshold(threshold), .timeoutBits(timeoutBits),
    .irqEnable(irqEnable), .clearOverrun(clearOverrun), .clearTimeout(clearTimeout),
    .overrun(overrun), .timeout(timeout), .irq(irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b, input bit accepted);
    rxDataValid = 1'b1;
    rxDataIn    = b;
    if (accepted) sb.push_back(b);
    tick();
    rxDataValid = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_vld"}, 32'(dataValid), 32'd1);
      chk({tag, "_dat"}, 32'(dataOut), 32'(exp));
    end
    readRequest = 1'b1;
    tick();
    readRequest = 1'b0;
  endtask

  initial begin
    int  n;
    bit  seen;
    logic [7:0] exp;

    rst = 1'b1; enable = 1'b1; flush = 1'b0; cyclesPerBit = 16'd9;
    rxDataIn = 8'h00; rxDataValid = 1'b0; readRequest = 1'b0;
    threshold = 5'd0; timeoutBits = 8'd0; irqEnable = 3'b000;
    clearOverrun = 1'b0; clearTimeout = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_dataOut", 32'(dataOut), 32'h0);
    chk("rst_dataValid", 32'(dataValid), 32'h0);
    chk("rst_count", 32'(fifoCount), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // Two bytes, FWFT head, pop
    strobe(8'h41, 1'b1);
    chk("fwft_first", 32'(dataOut), 32'h41);
    strobe(8'h42, 1'b1);
    chk("two_count", 32'(fifoCount), 32'd2);
    pop_chk("pop41");
    chk("after_pop_dat", 32'(dataOut), 32'h42);
    chk("after_pop_cnt", 32'(fifoCount), 32'd1);
    pop_chk("pop42");
    chk("drained_cnt", 32'(fifoCount), 32'd0);

    // Read while empty must not underflow
    readRequest = 1'b1; tick(); readRequest = 1'b0;
    chk("empty_pop_cnt", 32'(fifoCount), 32'd0);

    // Disabled receiver drops bytes silently
    enable = 1'b0;
    strobe(8'h77, 1'b0);
    chk("dis_cnt", 32'(fifoCount), 32'd0);
    chk("dis_overrun", 32'(overrun), 32'd0);
    enable = 1'b1;

    // Fill, overrun, clear
    for (int i = 0; i < 16; i++) strobe(8'(i), 1'b1);
    chk("full_cnt", 32'(fifoCount), 32'd16);
    chk("full_ovr", 32'(overrun), 32'd0);
    strobe(8'hAA, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_cnt", 32'(fifoCount), 32'd16);
    chk("ovr_head", 32'(dataOut), 32'h00);
    clearOverrun = 1'b1; tick(); clearOverrun = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'd0);

    // Push and pop together while full
    exp = sb.pop_front();
    chk("simul_head", 32'(dataOut), 32'(exp));
    sb.push_back(8'h55);
    rxDataValid = 1'b1; rxDataIn = 8'h55; readRequest = 1'b1;
    tick();
    rxDataValid = 1'b0; readRequest = 1'b0;
    chk("simul_ovr", 32'(overrun), 32'd0);
    chk("simul_cnt", 32'(fifoCount), 32'd16);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("drain%0d", i));
    chk("drain_cnt", 32'(fifoCount), 32'd0);

    // Idle timeout: 3 bit-times of 10 clocks
    timeoutBits = 8'd3;
    strobe(8'h33, 1'b1);
    n = 0;
    while (!timeout && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_lat", 32'(n), 32'd30);
    chk("timeout_irq_off", 32'(irq), 32'd0);
    irqEnable = 3'b010;
    tick();
    chk("timeout_irq", 32'(irq), 32'd1);
    irqEnable = 3'b000;
    pop_chk("pop33");
    chk("timeout_popclr", 32'(timeout), 32'd0);

    timeoutBits = 8'd0;
    strobe(8'h34, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (timeout) seen = 1'b1;
    end
    chk("timeout_disabled", 32'(seen), 32'd0);
    pop_chk("pop34");

    // Threshold interrupt
    threshold = 5'd4; irqEnable = 3'b001;
    tick();
    for (int i = 0; i < 4; i++) begin
      strobe(8'hC0 + 8'(i), 1'b1);
      chk($sformatf("thr_low%0d", i), 32'(irq), 32'd0);
    end
    chk("thr_cnt4", 32'(fifoCount), 32'd4);
    tick();
    chk("thr_rise", 32'(irq), 32'd1);
    pop_chk("thr_pop");
    chk("thr_cnt3", 32'(fifoCount), 32'd3);
    chk("thr_hold", 32'(irq), 32'd1);
    tick();
    chk("thr_fall", 32'(irq), 32'd0);
    for (int i = 0; i < 3; i++) pop_chk($sformatf("thr_drain%0d", i));
    threshold = 5'd0; irqEnable = 3'b000;

    // Overrun interrupt, then flush colliding with a push
    for (int i = 0; i < 16; i++) strobe(8'h80 + 8'(i), 1'b1);
    strobe(8'hEE, 1'b0);
    irqEnable = 3'b100;
    tick();
    chk("ovr_irq", 32'(irq), 32'd1);
    irqEnable = 3'b000;
    flush = 1'b1; rxDataValid = 1'b1; rxDataIn = 8'h99;
    tick();
    flush = 1'b0; rxDataValid = 1'b0;
    sb.delete();
    chk("flush_cnt", 32'(fifoCount), 32'd0);
    chk("flush_ovr", 32'(overrun), 32'd0);
    chk("flush_vld", 32'(dataValid), 32'd0);

    // Reset mid-stream
    strobe(8'h11, 1'b1);
    strobe(8'h12, 1'b1);
    rst = 1'b1; rxDataValid = 1'b1; rxDataIn = 8'h13;
    tick();
    rst = 1'b0; rxDataValid = 1'b0;
    sb.delete();
    chk("mrst_dataOut", 32'(dataOut), 32'h0);
    chk("mrst_vld", 32'(dataValid), 32'h0);
    chk("mrst_cnt", 32'(fifoCount), 32'h0);
    chk("mrst_flags", 32'({overrun, timeout, irq}), 32'h0);
    strobe(8'h5A, 1'b1);
    chk("mrst_cnt1", 32'(fifoCount), 32'd1);
    pop_chk("mrst_pop");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer_ctrl.md
Name: uart_rx_buffer_ctrl

Overview:
- Receive-side controller that sits between the UART receiver core and the peripheral's bus-facing register logic.
- Captures each byte the receiver reports on its one-cycle `rxDataValid` strobe into a FIFO.
- Presents bytes first-word-fall-through with a pop handshake.
- Detects overrun and character-idle timeout, and raises a single registered interrupt from enabled, threshold-based sources.

Parameters:
- CLOCK_SCALE_BITS, 16: width of `cyclesPerBit`; must match the receiver core.
- FIFO_ADDR_BITS, 4: FIFO depth is 2^FIFO_ADDR_BITS (16 entries); occupancy width is FIFO_ADDR_BITS+1.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  accept new bytes from the receiver core.
- flush  input  1  one-cycle pulse that empties the FIFO.
- cyclesPerBit  input  CLOCK_SCALE_BITS  same baud setting as given to the receiver core.
- rxDataIn  input  8  byte from the receiver core.
- rxDataValid  input  1  one-cycle strobe: rxDataIn is valid.
- readRequest  input  1  pop the head entry.
- dataOut  output  8  head entry (FWFT).
- dataValid  output  1  FIFO not empty.
- fifoCount  output  FIFO_ADDR_BITS+1  occupancy.
- threshold  input  FIFO_ADDR_BITS+1  interrupt level.
- timeoutBits  input  8  idle bit-times before timeout; 0 disables timeout.
- irqEnable  input  3  {overrun, timeout, threshold} enables.
- clearOverrun  input  1  clears the overrun flag.
- clearTimeout  input  1  clears the timeout flag.
- overrun  output  1  sticky overrun flag.
- timeout  output  1  sticky timeout flag.
- irq  output  1  registered interrupt.

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO empty; pointers and count are 0.
  - dataOut=0, dataValid=0, fifoCount=0, overrun=0, timeout=0, irq=0.
  - Prescaler and idle counter are 0.
  - Reset mid-byte discards the whole FIFO contents.
- Push:
  - A push occurs when rxDataValid && enable && (!full || pop this cycle).
  - The written byte is visible on dataOut the next cycle if the FIFO was empty.
  - A push while enable=0 is silently dropped; no overrun.
- Pop:
  - A pop occurs when readRequest && !empty.
  - The head advances at the clock edge; dataOut updates the next cycle.
  - readRequest while empty is ignored; count never underflows.
- Simultaneous push and pop:
  - fifoCount is unchanged.
  - Legal even when full; no overrun, and the byte is accepted.
- Overrun:
  - Set when rxDataValid && enable && full && no pop; the incoming byte is dropped and stored data is unchanged.
  - Cleared by clearOverrun, flush or rst.
  - If set and clear occur in the same cycle, set wins.
- Pointers:
  - Wrap modulo 2^FIFO_ADDR_BITS.
  - full when count == 2^FIFO_ADDR_BITS; empty when count == 0.
- Flush:
  - Empties the FIFO and clears overrun, timeout and the idle counter.
  - Flush has priority over a push or pop in the same cycle; that byte is lost with no overrun.
- Idle timer:
  - The prescaler counts 0..cyclesPerBit, then wraps to 0 and increments idleBits, which saturates at 255.
  - Prescaler and idleBits reset to 0 on any push, any pop, or while empty.
  - timeout is set when idleBits == timeoutBits && timeoutBits != 0 && !empty.
  - timeout is cleared by clearTimeout, any pop, flush or rst; set wins over clearTimeout in the same cycle.
- irq:
  - Registered at each posedge from the current cycle's values: (irqEnable[0] && fifoCount >= threshold && threshold != 0) || (irqEnable[1] && timeout) || (irqEnable[2] && overrun).
  - Net latency is one cycle after the source condition becomes visible.
- Arithmetic: all counters are unsigned; the occupancy compare is full width (FIFO_ADDR_BITS+1 bits).

Decomposition:
- Shared UART package holds:
  - IRQ enable bit-index constants (IRQ_THRESHOLD=0, IRQ_TIMEOUT=1, IRQ_OVERRUN=2).
  - The default CLOCK_SCALE_BITS.
- One sub-module, uart_fifo: synchronous FWFT FIFO with push, pop, flush, count, full and empty.
- Prescaler, idle counter, flags and irq logic stay in uart_rx_buffer_ctrl.

Test Plan:
- After rst:
  - Strobe rxDataValid with 0x41, then 0x42 → dataValid=1, dataOut=0x41, fifoCount=2.
  - readRequest for one cycle → dataOut=0x42, fifoCount=1.
- Fill 16 bytes 0x00..0x0F, then strobe 0xAA:
  - Overrun=1, fifoCount=16, and the 16 reads return 0x00..0x0F; 0xAA is never read.
  - clearOverrun → overrun=0.
- With the FIFO full, strobe 0x55 and assert readRequest in the same cycle → no overrun, fifoCount=16, last read = 0x55.
- cyclesPerBit=9, timeoutBits=3, one byte pushed, no reads:
  - timeout=1 exactly 30 cycles after the push.
  - Pop → timeout=0.
  - With timeoutBits=0, timeout is never set.
- threshold=4, irqEnable=3'b001:
  - irq rises one cycle after fifoCount reaches 4.
  - irq falls one cycle after fifoCount drops to 3.
- Mid-stream:
  - flush in the same cycle as a push → fifoCount=0, overrun=0, dataValid=0.
  - rst mid-stream → all outputs 0 the next cycle.
